// File: rtl/cacc_dbuf_ram_ctrl.sv
// Credit-based read controller for the CACC delivery buffer: payloads land in a DEPTH-entry RAM
// with RD_LAT read latency and drain through an RD_LAT+1 entry flop FIFO that can never overflow.
module cacc_dbuf_ram_ctrl #(
  parameter int DW     = 288,
  parameter int AW     = 5,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 2
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic          ram_we,
  output logic [AW-1:0] ram_wadr,
  output logic [DW-1:0] ram_wd,
  output logic          ram_re,
  output logic [AW-1:0] ram_radr,
  input  logic [DW-1:0] ram_rd,
  output logic [5:0]    occ
);
  localparam int OBD = RD_LAT + 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int OW  = $clog2(OBD + 1);
  localparam int IW  = $clog2(RD_LAT + 1);
  localparam int PW  = (OBD > 1) ? $clog2(OBD) : 1;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     ram_cnt_q, ram_cnt_d;
  logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
  logic [OW-1:0]     ob_cnt_q, ob_cnt_d;
  logic [PW-1:0]     ob_wp_q, ob_wp_d, ob_rp_q, ob_rp_d;
  logic [5:0]        occ_q, occ_d;
  logic [IW-1:0]     inflight, inflight_d;
  logic [DW-1:0]     ob_mem [OBD];
  logic              wr_acc, rd_issue, capture, pop;

  // Write side: accept is gated by reset so nothing reaches the RAM on the asserting edge.
  assign wr_prdy  = (ram_cnt_q < CW'(DEPTH));
  assign wr_acc   = wr_pvld & wr_prdy & nvdla_core_rstn;
  assign ram_we   = wr_acc;
  assign ram_wadr = wr_ptr_q;
  assign ram_wd   = wr_pd;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + IW'(rd_vld_q[i]);
  end

  // Read side: issue only when buffer credit covers every read still in flight.
  assign rd_pvld  = (ob_cnt_q != '0);
  assign rd_pd    = ob_mem[ob_rp_q];
  assign pop      = rd_pvld & rd_prdy;
  assign capture  = rd_vld_q[RD_LAT-1];
  assign rd_issue = (ram_cnt_q != '0) && nvdla_core_rstn &&
                    ((int'(inflight) + int'(ob_cnt_q) - int'(pop)) < OBD);
  assign ram_re   = rd_issue;
  assign ram_radr = rd_ptr_q;
  assign occ      = occ_q;

  always_comb begin
    wr_ptr_d   = wr_acc ? ((wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d   = rd_issue ? ((rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    case ({wr_acc, rd_issue})
      2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
      2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
      default: ram_cnt_d = ram_cnt_q;
    endcase
    rd_vld_d   = (rd_vld_q << 1) | RD_LAT'(rd_issue);
    inflight_d = inflight + IW'(rd_issue) - IW'(capture);
    ob_cnt_d   = ob_cnt_q + OW'(capture) - OW'(pop);
    ob_wp_d    = capture ? ((ob_wp_q == PW'(OBD - 1)) ? '0 : ob_wp_q + 1'b1) : ob_wp_q;
    ob_rp_d    = pop ? ((ob_rp_q == PW'(OBD - 1)) ? '0 : ob_rp_q + 1'b1) : ob_rp_q;
    occ_d      = 6'(ram_cnt_d) + 6'(inflight_d) + 6'(ob_cnt_d);
  end

  // Control state
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      rd_vld_q  <= '0;
      ob_cnt_q  <= '0;
      ob_wp_q   <= '0;
      ob_rp_q   <= '0;
      occ_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      rd_vld_q  <= rd_vld_d;
      ob_cnt_q  <= ob_cnt_d;
      ob_wp_q   <= ob_wp_d;
      ob_rp_q   <= ob_rp_d;
      occ_q     <= occ_d;
    end
  end

  // Output buffer payload capture at the end of cycle issue+RD_LAT
  always_ff @(posedge nvdla_core_clk) begin
    if (capture) ob_mem[ob_wp_q] <= ram_rd;
  end

endmodule

// File: tb/tb_cacc_dbuf_ram_ctrl.sv
// Randomized bench for cacc_dbuf_ram_ctrl: a latency-RAM model feeds the DUT and a count/queue
// reference model predicts every handshake, address, payload and occupancy value per cycle.
module tb_cacc_dbuf_ram_ctrl;
  localparam int DW     = 288;
  localparam int AW     = 5;
  localparam int DEPTH  = 32;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_pvld = 1'b0, wr_prdy;
  logic [DW-1:0] wr_pd = '0;
  logic          rd_pvld, rd_prdy = 1'b0;
  logic [DW-1:0] rd_pd;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_wadr, ram_radr;
  logic [DW-1:0] ram_wd, ram_rd = '0;
  logic [5:0]    occ;

  cacc_dbuf_ram_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_we(ram_we), .ram_wadr(ram_wadr), .ram_wd(ram_wd),
    .ram_re(ram_re), .ram_radr(ram_radr), .ram_rd(ram_rd),
    .occ(occ)
  );

  always #5 clk = ~clk;

  // RAM with two-cycle read latency: read issued in cycle t shows on ram_rd in cycle t+2.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_s1;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wadr] <= ram_wd;
    if (ram_re) ram_s1 <= mem[ram_radr];
    ram_rd <= ram_s1;
  end

  int errors = 0;
  int checks = 0;
  int acc, iss, pops, cap, cyc, re_seen;
  logic [DW-1:0] exp_q[$];
  int            iss_cyc[$];
  logic [DW-1:0] last_pd_seen;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    acc = 0; iss = 0; pops = 0; cap = 0;
    exp_q.delete();
    iss_cyc.delete();
  endtask

  // One clock cycle: drive inputs, predict and compare every output, then advance the model.
  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr);
    logic e_rdy, e_we, e_pvld, e_pop, e_re;
    @(negedge clk);
    wr_pvld = wv; wr_pd = wd; rd_prdy = rr;
    #1;
    while (iss_cyc.size() > 0 && iss_cyc[0] + RD_LAT + 1 <= cyc) begin
      void'(iss_cyc.pop_front());
      cap++;
    end
    e_rdy  = (acc - iss) < DEPTH;
    e_we   = wv && e_rdy;
    e_pvld = cap > pops;
    e_pop  = e_pvld && rr;
    e_re   = ((acc - iss) > 0) && ((iss - pops - int'(e_pop)) < RD_LAT + 1);
    chk("wr_prdy", DW'(wr_prdy), DW'(e_rdy));
    chk("occ", DW'(occ), DW'(acc - pops));
    chk("rd_pvld", DW'(rd_pvld), DW'(e_pvld));
    if (e_pvld && exp_q.size() > 0) chk("rd_pd", rd_pd, exp_q[0]);
    chk("ram_we", DW'(ram_we), DW'(e_we));
    if (e_we) begin
      chk("ram_wadr", DW'(ram_wadr), DW'(acc % DEPTH));
      chk("ram_wd", ram_wd, wd);
    end
    chk("ram_re", DW'(ram_re), DW'(e_re));
    chk("ram_radr", DW'(ram_radr), DW'(iss % DEPTH));
    if (ram_re) re_seen++;
    if (rd_pvld && rd_prdy) last_pd_seen = rd_pd;
    if (e_we) begin exp_q.push_back(wd); acc++; end
    if (e_re) begin iss_cyc.push_back(cyc); iss++; end
    if (e_pop) begin void'(exp_q.pop_front()); pops++; end
    cyc++;
  endtask

  initial begin
    int n, acc0, pops0;
    logic [DW-1:0] pat;
    cyc = 0; re_seen = 0;
    model_clear();

    // Reset state, with a write request pending to show it is not forwarded.
    wr_pvld = 1'b1;
    #12;
    chk("rst_rd_pvld", DW'(rd_pvld), '0);
    chk("rst_ram_we", DW'(ram_we), '0);
    chk("rst_ram_re", DW'(ram_re), '0);
    chk("rst_ram_radr", DW'(ram_radr), '0);
    chk("rst_occ", DW'(occ), '0);
    @(negedge clk);
    wr_pvld = 1'b0;
    rst_n = 1'b1;

    // Single write of A5 pattern with the sink ready.
    pat = {36{8'hA5}};
    step(1'b1, pat, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);
    chk("single_out", last_pd_seen, pat);
    chk("single_occ0", DW'(occ), '0);

    // 35 back-to-back writes with the sink stalled, then drain.
    re_seen = 0;
    for (int i = 0; i < 40; i++) step(1'b1, DW'(1000 + i) ^ (DW'($urandom()) << 64), 1'b0);
    chk("full_occ", DW'(occ), DW'(35));
    chk("full_reads", DW'(re_seen), DW'(3));
    chk("full_wr_prdy", DW'(wr_prdy), '0);
    for (int i = 0; i < 45; i++) step(1'b0, '0, 1'b1);
    chk("drain_occ", DW'(occ), '0);
    chk("drain_wr_prdy", DW'(wr_prdy), DW'(1));
    chk("drain_empty", DW'(exp_q.size()), '0);

    // 100 incrementing payloads against a randomly stalling sink.
    n = 0; acc0 = acc; pops0 = pops;
    for (int i = 0; i < 2000 && n < 100; i++) begin
      step(1'b1, DW'(n), 1'($urandom_range(0, 1)));
      n = acc - acc0;
    end
    chk("stream_accepts", DW'(n), DW'(100));
    for (int i = 0; i < 200 && (pops - pops0) < 100; i++) step(1'b0, '0, 1'($urandom_range(0, 1)));
    chk("stream_delivered", DW'(pops - pops0), DW'(100));
    chk("stream_last", last_pd_seen, DW'(99));

    // Reset mid-operation with reads in flight and buffered data.
    for (int i = 0; i < 8; i++) step(1'b1, DW'(500 + i), 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, DW'(600 + i), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    wr_pvld = 1'b1;
    #1;
    chk("mid_rst_rd_pvld", DW'(rd_pvld), '0);
    chk("mid_rst_ram_re", DW'(ram_re), '0);
    chk("mid_rst_ram_we", DW'(ram_we), '0);
    chk("mid_rst_occ", DW'(occ), '0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    wr_pvld = 1'b0;
    rst_n = 1'b1;
    last_pd_seen = '0;
    step(1'b1, DW'(1), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    chk("post_rst_pops", DW'(pops), DW'(1));
    chk("post_rst_first", last_pd_seen, DW'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
